// File: rtl/jtopl_pkg.sv
// Shared constants and types for the slot capture block.
package jtopl_pkg;

    // Width of a slot index; covers up to 32 slots per frame.
    localparam int SLOT_W = 5;

    // Read transaction states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/jtopl_slot_ram.sv
// Slot register bank: synchronous write, combinational read by index.
module jtopl_slot_ram
    import jtopl_pkg::*;
#(
    parameter int   width  = 5,
    parameter int   slots  = 18,
    parameter logic rstval = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SLOT_W-1:0] wr_idx,
    input  logic [width-1:0]  wr_data,
    input  logic [SLOT_W-1:0] rd_idx,
    output logic [width-1:0]  rd_q
);

    localparam logic [SLOT_W:0] NSLOT = (SLOT_W+1)'(slots);

    logic [width-1:0] bank [slots];

    // Reset fills every entry with rstval; otherwise write the indexed slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < slots; i++) bank[i] <= {width{rstval}};
        end else if (we) begin
            bank[wr_idx] <= wr_data;
        end
    end

    // Out-of-range indices read back as zero instead of an undefined entry.
    always_comb begin
        rd_q = '0;
        if ({1'b0, rd_idx} < NSLOT) rd_q = bank[rd_idx];
    end

endmodule

// File: rtl/jtopl_slot_cap.sv
// Slot capture: tracks the time-multiplexed slot stream, stores each slot
// sample in a bank and serves single-slot read requests with fresh data.
module jtopl_slot_cap
    import jtopl_pkg::*;
#(
    parameter int   width  = 5,
    parameter int   slots  = 18,
    parameter logic rstval = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [width-1:0]  din,
    input  logic              zero,
    input  logic              rd_req,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic              rd_ack,
    output logic [width-1:0]  rd_data,
    output logic              rd_err,
    output logic              sync_err
);

    localparam logic [SLOT_W:0]   NSLOT = (SLOT_W+1)'(slots);
    localparam logic [SLOT_W-1:0] LAST  = SLOT_W'(slots - 1);

    logic [SLOT_W-1:0] cnt;
    logic [SLOT_W-1:0] idx;
    logic [SLOT_W-1:0] slot_q;
    logic              err_q;
    logic              hit;
    logic              oor;
    logic [width-1:0]  peek_unused;
    rd_state_t         state, nxt;

    // zero forces slot 0 so the counter resynchronises on every frame marker.
    assign idx = zero ? '0 : cnt;
    assign hit = cen && (idx == slot_q);
    assign oor = {1'b0, rd_slot} >= NSLOT;

    // Bank write port follows the stream; read port peeks the latched slot.
    jtopl_slot_ram #(
        .width  (width),
        .slots  (slots),
        .rstval (rstval)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (cen),
        .wr_idx  (idx),
        .wr_data (din),
        .rd_idx  (slot_q),
        .rd_q    (peek_unused)
    );

    // Slot counter: advance past the current index, wrapping at frame end.
    always_ff @(posedge clk) begin
        if (!rst)     cnt <= '0;
        else if (cen) cnt <= (idx == LAST) ? '0 : idx + 1'b1;
    end

    // Frame marker arriving while the counter is mid-frame flags misalignment.
    always_ff @(posedge clk) begin
        if (!rst) sync_err <= 1'b0;
        else      sync_err <= cen && zero && (cnt != '0);
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    // Read FSM next state: range check, wait for the slot to pass, then ack.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (rd_req) nxt = oor ? ST_ACK : ST_WAIT;
            ST_WAIT: if (hit)    nxt = ST_ACK;
            ST_ACK:              nxt = ST_IDLE;
            default:             nxt = ST_IDLE;
        endcase
    end

    // Request latch, data capture and registered ack/err outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q  <= '0;
            err_q   <= 1'b0;
            rd_data <= '0;
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            rd_ack <= (state == ST_ACK);
            rd_err <= (state == ST_ACK) && err_q;
            if (state == ST_IDLE && rd_req) begin
                slot_q <= rd_slot;
                err_q  <= oor;
                if (oor) rd_data <= '0;
            end
            // Capture straight from the stream so the sample postdates the request.
            if (state == ST_WAIT && hit) rd_data <= din;
        end
    end

endmodule

// File: tb/tb_jtopl_slot_cap.sv
// Randomised + directed bench for jtopl_slot_cap against a transaction-level model.
module tb_jtopl_slot_cap;
    localparam int W = 5;
    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cen = 1'b0;
    logic [W-1:0] din = '0;
    logic         zero = 1'b0;
    logic         rd_req = 1'b0;
    logic [4:0]   rd_slot = '0;
    logic         rd_ack;
    logic [W-1:0] rd_data;
    logic         rd_err;
    logic         sync_err;

    jtopl_slot_cap #(.width(W), .slots(N), .rstval(1'b0)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .zero(zero),
        .rd_req(rd_req), .rd_slot(rd_slot), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_err(rd_err), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;

    // Model: frame position, stored samples, and the outstanding request.
    int         edge_no = 0;
    int         mcnt = 0;
    logic [W-1:0] mbank [N];
    bit         pending = 0;
    int         pslot = 0;
    bit         perr = 0;
    int         ack_at = -10;
    bit         exp_ack = 0, exp_err = 0, exp_sync = 0;
    logic [W-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int idx;
        edge_no++;
        if (!rst) begin
            mcnt = 0;
            for (int i = 0; i < N; i++) mbank[i] = '0;
            pending = 0; ack_at = -10; perr = 0;
            exp_ack = 0; exp_err = 0; exp_sync = 0; exp_data = '0;
            return;
        end
        idx = zero ? 0 : mcnt;
        exp_ack = (ack_at == edge_no);
        exp_err = exp_ack && perr;
        exp_sync = cen && zero && (mcnt != 0);
        if (pending) begin
            if (cen && idx == pslot) begin
                exp_data = din;
                ack_at = edge_no + 1;
                pending = 0;
            end
        end else if (ack_at < edge_no && rd_req) begin
            pslot = rd_slot;
            perr = (rd_slot >= N);
            if (perr) begin
                exp_data = '0;
                ack_at = edge_no + 1;
            end else begin
                pending = 1;
            end
        end
        if (cen) begin
            mbank[idx] = din;
            mcnt = (idx + 1) % N;
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (rd_ack === 1'b1) n_ack++;
        chk("rd_ack", rd_ack, exp_ack);
        chk("rd_err", rd_err, exp_err);
        chk("sync_err", sync_err, exp_sync);
        chk("rd_data", rd_data, exp_data);
        chk("cnt", dut.cnt, mcnt);
        for (int i = 0; i < N; i++) chk("bank", dut.u_ram.bank[i], mbank[i]);
    endtask

    task automatic feed_next(input logic [W-1:0] d);
        cen = 1; zero = (mcnt == 0); din = d;
        tick();
    endtask

    task automatic req(input int s);
        cen = 0; zero = 0; rd_req = 1; rd_slot = 5'(s);
        tick();
        rd_req = 0;
    endtask

    initial begin
        int  acks0;
        bit  seen;
        int  tgt;

        // Reset state
        rst = 0; cen = 1; zero = 1; rd_req = 1; rd_slot = 5'd2;
        repeat (3) tick();
        chk("rst_ack", rd_ack, 0);
        chk("rst_cnt", dut.cnt, 0);
        rst = 1; rd_req = 0; cen = 0; zero = 0;
        tick();

        // Fresh frame of slot+1, then read slot 5 on the next pass
        for (int s = 0; s < N; s++) feed_next(W'(s + 1));
        req(5);
        seen = 0;
        for (int n = 0; n < N && !seen; n++) begin
            feed_next(W'(mcnt + 1));
            if (rd_ack === 1'b1) begin
                seen = 1;
                chk("t032_data", rd_data, 6);
                chk("t032_err", rd_err, 0);
            end
        end
        if (!seen) chk("t032_ack_timeout", 0, 1);
        cen = 0;

        // Out-of-range slot acks two clocks after latch without cen
        req(20);
        chk("t033_early", rd_ack, 0);
        tick();
        chk("t033_ack", rd_ack, 1);
        chk("t033_err", rd_err, 1);
        chk("t033_data", rd_data, 0);
        tick();

        // Misplaced frame marker at cnt=7
        for (int n = 0; n < N && mcnt != 0; n++) feed_next(5'd2);
        repeat (7) feed_next(5'd3);
        chk("t034_cnt7", dut.cnt, 7);
        cen = 1; zero = 1; din = 5'd9; tick();
        chk("t034_sync", sync_err, 1);
        cen = 1; zero = 0; din = 5'h0A; tick();
        chk("t034_sync_off", sync_err, 0);
        chk("t034_slot1", dut.u_ram.bank[1], 5'h0A);
        chk("t034_cnt", dut.cnt, 2);

        // Fresh data wins over the stored value for slot 3
        cen = 0; zero = 0;
        req(3);
        seen = 0;
        for (int n = 0; n < N + 1 && !seen; n++) begin
            feed_next((mcnt == 3) ? 5'h1F : 5'h04);
            if (rd_ack === 1'b1) begin
                seen = 1;
                chk("t035_data", rd_data, 5'h1F);
            end
        end
        if (!seen) chk("t035_ack_timeout", 0, 1);

        // Reset during WAIT abandons the request
        for (int n = 0; n < N && mcnt != 0; n++) feed_next(5'd1);
        req(10);
        repeat (3) feed_next(5'd7);
        acks0 = n_ack;
        rst = 0; cen = 1; zero = 1; rd_req = 1; rd_slot = 5'd4;
        repeat (2) tick();
        chk("t036_cnt", dut.cnt, 0);
        chk("t036_data", rd_data, 0);
        for (int i = 0; i < N; i++) chk("t036_bank", dut.u_ram.bank[i], 0);
        rst = 1; rd_req = 0;
        repeat (40) feed_next(5'd5);
        chk("t036_no_ack", n_ack - acks0, 0);

        // cen stalled for 50 clocks during WAIT
        tgt = (mcnt + 5) % N;
        req(tgt);
        acks0 = n_ack;
        cen = 0;
        for (int n = 0; n < 50; n++) begin
            zero = n[0]; din = W'($urandom);
            tick();
        end
        chk("t037_no_ack", n_ack - acks0, 0);
        zero = 0;
        seen = 0;
        for (int n = 0; n < N + 1 && !seen; n++) begin
            feed_next(5'h11);
            if (rd_ack === 1'b1) seen = 1;
        end
        if (!seen) chk("t037_ack_timeout", 0, 1);

        // Random traffic with occasional resets and frame glitches
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom % 300) != 0;
            cen     = ($urandom % 3) != 0;
            zero    = (mcnt == 0) ? (($urandom % 20) != 0) : (($urandom % 80) == 0);
            din     = W'($urandom);
            rd_req  = ($urandom % 4) == 0;
            rd_slot = (($urandom % 8) == 0) ? 5'(18 + $urandom % 14) : 5'($urandom % 18);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jtopl_slot_cap.md
JTOPL_SLOT_CAP -- requirements
Module: jtopl_slot_cap

Interface
REQ-001 SHALL have parameter width, default 5, bit width of each slot sample.
REQ-002 SHALL have parameter slots, default 18, number of time-multiplexed slots per frame; must be at least 3 and at most 32.
REQ-003 SHALL have parameter rstval, default 1'b0, bit value replicated into every bank entry at reset.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset (asserted when 0).
REQ-006 SHALL have port cen, input, 1, slot-advance clock enable; one slot per cen cycle.
REQ-007 SHALL have port din, input, width, time-multiplexed slot sample taken from the delay-chain output.
REQ-008 SHALL have port zero, input, 1, high on the cen cycle where din carries slot 0.
REQ-009 SHALL have port rd_req, input, 1, level read request, sampled only in IDLE.
REQ-010 SHALL have port rd_slot, input, 5, requested slot index, latched with rd_req.
REQ-011 SHALL have port rd_ack, output, 1, one-clk pulse that qualifies rd_data and rd_err.
REQ-012 SHALL have port rd_data, output, width, returned sample, held until the next rd_ack.
REQ-013 SHALL have port rd_err, output, 1, high with rd_ack when the latched slot is at or above slots.
REQ-014 SHALL have port sync_err, output, 1, one-clk pulse on a frame misalignment.

Function
REQ-015 SHALL compute the current index idx as 0 when zero=1, otherwise the slot counter cnt.
REQ-016 SHALL on every clk with cen=1 write din to bank[idx] and load cnt with idx+1, wrapping from slots-1 to 0.
REQ-017 SHALL hold cnt and bank unchanged when cen=0, with zero and din ignored.
REQ-018 SHALL pulse sync_err for one clk when cen=1, zero=1 and cnt is not 0, and SHALL still resync cnt to 1 on that cycle.
REQ-019 SHALL implement the read FSM with states IDLE, WAIT and ACK.
REQ-020 SHALL in IDLE with rd_req=1 latch rd_slot; go to ACK when the latched slot is at or above slots, otherwise go to WAIT.
REQ-021 SHALL in WAIT, on a cen=1 cycle where idx equals the latched slot, capture din into rd_data and go to ACK, so the returned sample is always one written after the request.
REQ-022 SHALL in ACK drive rd_ack=1 for exactly one clk and return to IDLE; rd_err=1 and rd_data=0 for an out-of-range slot.
REQ-023 SHALL in IDLE start a new transaction on the clk after ACK if rd_req is still 1; there is no back-to-back ack without an intervening WAIT or range check.
REQ-024 SHALL ignore rd_slot changes outside IDLE.
REQ-025 SHALL bound worst-case read latency from latch to rd_ack at slots cen cycles plus 2 clk.

Reset
REQ-026 SHALL while rst=0 at a clk edge set cnt=0, state=IDLE, rd_ack=0, rd_err=0, sync_err=0, rd_data=0, and every bank bit to rstval.
REQ-027 SHALL abort an in-flight WAIT when reset is asserted, with no rd_ack issued for that request.
REQ-028 SHALL take reset over cen, zero and rd_req arriving in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding and the 5-bit slot-index width constant in the shared package jtopl_pkg.
REQ-030 SHALL use a single sub-module, jtopl_slot_ram: a slots x width register bank with a synchronous write and a combinational read by index (debug/peek use).
REQ-031 SHALL keep the counter, sync check and FSM in jtopl_slot_cap itself.

Verification (width=5, slots=18)
REQ-032 SHALL verify: feed din=slot+1 for slots 0..17 with zero on slot 0, then rd_req with rd_slot=5 -> rd_ack within 18 cen cycles, rd_data=6, rd_err=0.
REQ-033 SHALL verify: rd_slot=20 -> rd_ack 2 clk after latch, rd_err=1, rd_data=0, no wait on cen.
REQ-034 SHALL verify: zero asserted when cnt=7 -> sync_err pulses one clk, and the next cen writes slot 1.
REQ-035 SHALL verify: request slot 3, change din for slot 3 to 5'h1F before the next pass -> rd_data=5'h1F, not the older value.
REQ-036 SHALL verify: rst=0 during WAIT -> no rd_ack ever, cnt=0, rd_data=0, and all bank entries equal rstval.
REQ-037 SHALL verify: cen held low for 50 clk during WAIT -> no rd_ack and cnt frozen; rd_ack follows once cen resumes and the slot arrives.
